uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with a small byte FIFO feeding the bit-timing FSM.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | driving the start bit (0)
// DATA   | shifting out data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit (1); chains straight into START if more bytes wait
module uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        uart_clk,
  input  logic        uart_rst_n,
  input  logic [15:0] uart_divider,
  input  logic [7:0]  uart_tx_data,
  input  logic        uart_tx_valid,
  output logic        uart_tx_ready,
  output logic        uart_ser_tx,
  output logic        uart_tx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] div_q, div_d;
  logic        tx_q, tx_d;
  logic        bit_end, load;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign uart_tx_ready = (count_q != FULL_CNT);
  assign uart_tx_busy  = (state_q != IDLE) || (count_q != '0);
  assign uart_ser_tx   = tx_q;
  assign push          = uart_tx_valid && uart_tx_ready;
  assign bit_end       = (cyc_q == div_q);

  always_ff @(posedge uart_clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_tx_data;
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_d     = cyc_q;
    div_d     = div_q;
    tx_d      = tx_q;
    load      = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cyc_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (count_q != '0) begin
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Frame start is shared by IDLE and the gapless STOP->START chain.
    if (load) begin
      pop       = 1'b1;
      shift_d   = mem_q[rd_ptr_q];
      div_d     = uart_divider;
      bit_cnt_d = '0;
      cyc_d     = '0;
      tx_d      = 1'b0;
      state_d   = START;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^mem_q[rd_ptr_q];
`endif
    end
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_q     <= '0;
      div_q     <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_q     <= cyc_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: latency, bit timing, back-to-back frames,
// FIFO fill/backpressure, divider latching, async reset mid-frame.
module tb_uart_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] divider;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ser_tx;
  logic        tx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx #(.FIFO_DEPTH(4)) dut (
    .uart_clk      (clk),
    .uart_rst_n    (rst_n),
    .uart_divider  (divider),
    .uart_tx_data  (tx_data),
    .uart_tx_valid (tx_valid),
    .uart_tx_ready (tx_ready),
    .uart_ser_tx   (ser_tx),
    .uart_tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; offers one byte and returns at the negedge after it was taken.
  task automatic push_byte(input logic [7:0] b, output int waited);
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
  endtask

  // Waits up to max_wait negedges for the start bit, then checks every cycle of the frame.
  task automatic expect_frame(input string tag, input int div, input logic [7:0] data,
                              input int max_wait);
    logic [10:0] fr;
    logic [10:0] rx;
    int nb;
    int waited;
    int errs;
    fr = '1;
    rx = '0;
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, ^data, data, 1'b0};
    nb = 11;
`else
    fr[9:0] = {1'b1, data, 1'b0};
    nb = 10;
`endif
    waited = 0;
    errs   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ser_tx !== 1'b0 && waited < max_wait);
    check({tag, "_start"}, {31'd0, ser_tx}, 32'd0);
    if (ser_tx !== 1'b0) return;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c <= div; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (ser_tx !== fr[k]) errs++;
        if (c == div / 2) rx[k] = ser_tx;
      end
    end
    check({tag, "_bits"}, errs, 0);
    check({tag, "_byte"}, {24'd0, rx[8:1]}, {24'd0, data});
  endtask

  initial begin
    int w;
    logic [7:0] q5 [5];
    q5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst_n    = 1'b0;
    divider  = 16'd3;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ser", {31'd0, ser_tx}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55 at divider 3: line falls the edge after acceptance, 40-cycle frame
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t1_pre_ser", {31'd0, ser_tx}, 32'd1);
    check("t1_pre_busy", {31'd0, tx_busy}, 32'd1);
    expect_frame("t1", 3, 8'h55, 1);
    @(negedge clk);
    check("t1_busy_end", {31'd0, tx_busy}, 32'd0);
    check("t1_idle_ser", {31'd0, ser_tx}, 32'd1);

    // three back-to-back frames with no idle gap
    divider = 16'd2;
    fork
      begin
        push_byte(8'hA5, w);
        push_byte(8'h3C, w);
        push_byte(8'hFF, w);
        tx_valid = 1'b0;
      end
      begin
        expect_frame("t2a", 2, 8'hA5, 2);
        expect_frame("t2b", 2, 8'h3C, 1);
        expect_frame("t2c", 2, 8'hFF, 1);
      end
    join
    @(negedge clk);
    check("t2_busy_end", {31'd0, tx_busy}, 32'd0);

    // FIFO fill: five bytes accepted (one in shifter + four queued), sixth refused
    divider = 16'd100;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push_byte(q5[i], w);
          check("t3_nowait", w, 0);
        end
        tx_data = 8'h99;
        check("t3_full_ready", {31'd0, tx_ready}, 32'd0);
        repeat (50) @(negedge clk);
        check("t3_still_full", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
      end
      begin
        expect_frame("t3_0", 100, 8'h11, 2);
        for (int i = 1; i < 5; i++) expect_frame("t3_n", 100, q5[i], 1);
      end
    join
    @(negedge clk);
    check("t3_busy_end", {31'd0, tx_busy}, 32'd0);

    // divider 0: one cycle per bit
    divider  = 16'd0;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    expect_frame("t4", 0, 8'h01, 1);
    @(negedge clk);
    check("t4_busy_end", {31'd0, tx_busy}, 32'd0);

    // divider changed mid-frame only takes effect on the next frame
    divider = 16'd3;
    fork
      begin
        push_byte(8'h0F, w);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        divider = 16'd7;
      end
      expect_frame("t5_old_div", 3, 8'h0F, 2);
    join
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    expect_frame("t5_new_div", 7, 8'hF0, 1);
    @(negedge clk);

`ifdef UART_TX_PARITY_EN
    divider  = 16'd1;
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    expect_frame("par_07", 1, 8'h07, 1);
    @(negedge clk);
    tx_data  = 8'h03;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    expect_frame("par_03", 1, 8'h03, 1);
    @(negedge clk);
`endif

    // async reset mid-DATA with two bytes queued
    divider = 16'd10;
    push_byte(8'h00, w);
    push_byte(8'hC3, w);
    push_byte(8'h5A, w);
    tx_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("t6_mid_low", {31'd0, ser_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ser", {31'd0, ser_tx}, 32'd1);
    check("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
    check("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1 || tx_busy !== 1'b0) w++;
    end
    check("t6_no_frames", w, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
